// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the UART echo block.
package uart_pkg;

  localparam int unsigned BAUD_CNT   = 56;
  localparam int unsigned BIT_SAMPLE = BAUD_CNT / 2;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

endpackage

// File: rtl/uart_loopback_if.sv
// Serial line pair of the echo block; master is the remote end, slave is the echo block.
interface uart_loopback_if;

  logic rs232_rx;
  logic rs232_tx;

  modport master (
    output rs232_rx,
    input  rs232_tx
  );

  modport slave (
    input  rs232_rx,
    output rs232_tx
  );

endinterface

// File: rtl/sync_fifo.sv
// Small byte FIFO between receiver and transmitter; pushes into a full FIFO are dropped
// unless a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   count_q;
  logic             full, push, pop;

  // Push/pop qualification; a full FIFO is never empty, so a valid pop always frees a slot.
  always_comb begin
    full    = (count_q == (AddrW + 1)'(Depth));
    empty_o = (count_q == '0);
    pop     = rd_en_i && !empty_o;
    push    = wr_en_i && (!full || pop);
    rd_data_o = mem_q[rptr_q];
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge sclk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge sclk) begin
    if (s_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AddrW'(1);
      if (pop)  rptr_q <= rptr_q + AddrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AddrW + 1)'(1);
        2'b01:   count_q <= count_q - (AddrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronizes the line, detects a start edge, samples each bit mid-period.
module uart_rx import uart_pkg::*; #(
  parameter int unsigned BaudCnt = BAUD_CNT
) (
  input  logic                 sclk,
  input  logic                 s_rst_n,
  input  logic                 rx_i,
  output logic                 rx_done_o,
  output logic [DATA_BITS-1:0] rx_data_o
);

  localparam int unsigned CntW = $clog2(BaudCnt);
  localparam logic [CntW-1:0] CntLast = CntW'(BaudCnt - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'(BaudCnt / 2);
  localparam logic [2:0]      BitLast = 3'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0]      cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 fall, bit_mid, bit_end;

  assign fall    = rx_prev_q && !rx_sync_q;
  assign bit_mid = (cnt_q == CntMid);
  assign bit_end = (cnt_q == CntLast);

  // Two-flop synchronizer plus one history flop for edge detection; resets to idle-high.
  always_ff @(posedge sclk) begin
    if (s_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // State register.
  always_ff @(posedge sclk) begin
    if (s_rst_n) state_q <= RxIdle;
    else         state_q <= state_d;
  end

  // Next-state logic; a high line at mid-start is a glitch, stop returns to idle at mid-bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RxIdle:  if (fall) state_d = RxStart;
      RxStart: begin
        if (bit_mid && rx_sync_q) state_d = RxIdle;
        else if (bit_end)         state_d = RxData;
      end
      RxData:  if (bit_end && bit_q == BitLast) state_d = RxStop;
      RxStop:  if (bit_mid) state_d = RxIdle;
      default: state_d = RxIdle;
    endcase
  end

  // Bit timing counter, bit index and LSB-first shift register.
  always_ff @(posedge sclk) begin
    if (s_rst_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      if (state_q == RxIdle || state_d == RxIdle || bit_end) cnt_q <= '0;
      else                                                   cnt_q <= cnt_q + CntW'(1);
      if (state_q != RxData) bit_q <= '0;
      else if (bit_end)      bit_q <= bit_q + 3'd1;
      if (state_q == RxData && bit_mid) shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
    end
  end

  // Byte is valid only when the stop bit samples high.
  always_comb begin
    rx_done_o = (state_q == RxStop) && bit_mid && rx_sync_q;
    rx_data_o = shift_q;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: pops one byte from the FIFO and serializes it from a registered output.
module uart_tx import uart_pkg::*; #(
  parameter int unsigned BaudCnt = BAUD_CNT
) (
  input  logic                 sclk,
  input  logic                 s_rst_n,
  input  logic                 fifo_empty_i,
  input  logic [DATA_BITS-1:0] fifo_data_i,
  output logic                 fifo_pop_o,
  output logic                 tx_o
);

  localparam int unsigned CntW = $clog2(BaudCnt);
  localparam logic [CntW-1:0] CntLast = CntW'(BaudCnt - 1);
  localparam logic [2:0]      BitLast = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 tx_q, tx_d;
  logic                 bit_end;

  assign bit_end = (cnt_q == CntLast);
  assign tx_o    = tx_q;

  // State register.
  always_ff @(posedge sclk) begin
    if (s_rst_n) state_q <= TxIdle;
    else         state_q <= state_d;
  end

  // Next-state logic; the end of a stop bit chains straight into the next start if data waits.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TxIdle:  if (!fifo_empty_i) state_d = TxStart;
      TxStart: if (bit_end) state_d = TxData;
      TxData:  if (bit_end && bit_q == BitLast) state_d = TxStop;
      TxStop:  if (bit_end) state_d = fifo_empty_i ? TxIdle : TxStart;
      default: state_d = TxIdle;
    endcase
  end

  // Outputs: pop request and the next line level, which is registered so the line never glitches.
  always_comb begin
    fifo_pop_o = !fifo_empty_i && (state_q == TxIdle || (state_q == TxStop && bit_end));
    bit_d = bit_q;
    if (state_q != TxData) bit_d = '0;
    else if (bit_end)      bit_d = bit_q + 3'd1;
    unique case (state_d)
      TxStart: tx_d = 1'b0;
      TxData:  tx_d = data_q[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // Bit timing counter, bit index, byte latch and line register.
  always_ff @(posedge sclk) begin
    if (s_rst_n) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      data_q <= '0;
      tx_q   <= 1'b1;
    end else begin
      if (state_q == TxIdle || bit_end) cnt_q <= '0;
      else                              cnt_q <= cnt_q + CntW'(1);
      bit_q <= bit_d;
      if (fifo_pop_o) data_q <= fifo_data_i;
      tx_q <= tx_d;
    end
  end

endmodule

// File: rtl/uart_loopback_top.sv
// UART echo: every valid received byte is buffered and retransmitted unchanged.
module uart_loopback_top #(
  parameter int unsigned BAUD_CNT   = uart_pkg::BAUD_CNT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            sclk,
  input  logic            s_rst_n,
  uart_loopback_if.slave  serial
);

  import uart_pkg::*;

  logic                 rx_done;
  logic [DATA_BITS-1:0] rx_data;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 tx_line;

  assign serial.rs232_tx = tx_line;

  uart_rx #(
    .BaudCnt (BAUD_CNT)
  ) u_rx (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .rx_i      (serial.rs232_rx),
    .rx_done_o (rx_done),
    .rx_data_o (rx_data)
  );

  sync_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .wr_en_i   (rx_done),
    .wr_data_i (rx_data),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .empty_o   (fifo_empty)
  );

  uart_tx #(
    .BaudCnt (BAUD_CNT)
  ) u_tx (
    .sclk         (sclk),
    .s_rst_n      (s_rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_rdata),
    .fifo_pop_o   (fifo_pop),
    .tx_o         (tx_line)
  );

endmodule

// File: tb/tb_uart_loopback_top.sv
// Bench for the UART echo block: drives 8N1 frames, decodes the echo and compares to a byte queue.
module tb_uart_loopback_top;

  localparam int unsigned Bit   = 56;
  localparam int unsigned Frame = 10 * Bit;

  logic sclk    = 1'b0;
  logic s_rst_n = 1'b1;

  uart_loopback_if ser ();

  always #5 sclk = ~sclk;

  uart_loopback_top #(
    .BAUD_CNT   (Bit),
    .FIFO_DEPTH (4)
  ) dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .serial  (ser)
  );

  int unsigned n_checks    = 0;
  int unsigned n_fail      = 0;
  int unsigned cyc         = 0;
  int unsigned rst_cnt     = 0;
  int unsigned tx_low_cnt  = 0;
  int unsigned frames_seen = 0;
  logic [7:0]  exp_q [$];
  int unsigned start_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge sclk) begin
    cyc <= cyc + 1;
    if (s_rst_n) rst_cnt <= rst_cnt + 1;
  end

  always @(negedge sclk) begin
    if (ser.rs232_tx !== 1'b1) tx_low_cnt <= tx_low_cnt + 1;
  end

  // Echo decoder: samples the line mid-bit; frames overlapped by a reset are discarded.
  logic [7:0]  mon_d;
  int unsigned mon_st, mon_r0;
  logic        mon_ok_start, mon_ok_stop;
  initial begin
    forever begin
      @(negedge sclk);
      if (ser.rs232_tx === 1'b0 && !s_rst_n) begin
        mon_st = cyc;
        mon_r0 = rst_cnt;
        repeat (Bit / 2) @(negedge sclk);
        mon_ok_start = (ser.rs232_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (Bit) @(negedge sclk);
          mon_d[i] = ser.rs232_tx;
        end
        repeat (Bit) @(negedge sclk);
        mon_ok_stop = (ser.rs232_tx === 1'b1);
        if (rst_cnt == mon_r0) begin
          frames_seen++;
          start_q.push_back(mon_st);
          check_val("echo_start_bit", 32'(mon_ok_start), 32'd1);
          check_val("echo_stop_bit", 32'(mon_ok_stop), 32'd1);
          if (exp_q.size() == 0) check_val("echo_unexpected", 32'(exp_q.size()), 32'd1);
          else                   check_val("echo_byte", 32'(mon_d), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Drives one frame; call aligned to a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    ser.rs232_rx = 1'b0;
    repeat (Bit) @(negedge sclk);
    for (int i = 0; i < 8; i++) begin
      ser.rs232_rx = b[i];
      repeat (Bit) @(negedge sclk);
    end
    ser.rs232_rx = stop_bit;
    repeat (Bit) @(negedge sclk);
    ser.rs232_rx = 1'b1;
  endtask

  task automatic wait_frames(input string tag, input int unsigned target);
    int unsigned n = 0;
    while (frames_seen < target && n < 20000) begin
      @(negedge sclk);
      n++;
    end
    check_val(tag, frames_seen, target);
  endtask

  int unsigned k, base, low0, lat, n_good, n;
  logic [7:0]  b;
  logic        good;
  logic [7:0]  b2b [4];

  initial begin
    ser.rs232_rx = 1'b1;
    b2b[0] = 8'h12; b2b[1] = 8'h34; b2b[2] = 8'hAB; b2b[3] = 8'hCD;
    repeat (5) @(negedge sclk);
    check_val("reset_tx_high", 32'(ser.rs232_tx), 32'd1);
    s_rst_n = 1'b0;
    repeat (20) @(negedge sclk);

    // Single byte, with latency and exact low-time of the echo.
    low0 = tx_low_cnt;
    base = frames_seen;
    start_q.delete();
    k = cyc;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    wait_frames("single_count", base + 1);
    repeat (100) @(negedge sclk);
    lat = start_q[0] - (k + 9 * Bit + Bit / 2);
    check_val("single_latency_in_range", 32'(lat >= 2 && lat <= 6), 32'd1);
    // 0x55 has four zero data bits, plus the start bit.
    check_val("single_low_cycles", tx_low_cnt - low0, 5 * Bit);

    // Four contiguous frames must come back contiguous.
    base = frames_seen;
    start_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(b2b[i]);
    for (int i = 0; i < 4; i++) send_byte(b2b[i], 1'b1);
    wait_frames("b2b_count", base + 4);
    for (int i = 1; i < 4; i++) check_val("b2b_gap", start_q[i] - start_q[i-1], Frame);

    // Short low glitch produces nothing.
    repeat (600) @(negedge sclk);
    low0 = tx_low_cnt;
    base = frames_seen;
    ser.rs232_rx = 1'b0;
    repeat (10) @(negedge sclk);
    ser.rs232_rx = 1'b1;
    repeat (800) @(negedge sclk);
    check_val("glitch_no_echo", frames_seen, base);
    check_val("glitch_tx_high", tx_low_cnt, low0);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    wait_frames("after_glitch_count", base + 1);

    // Framing error drops the byte.
    repeat (200) @(negedge sclk);
    base = frames_seen;
    send_byte(8'h3C, 1'b0);
    repeat (800) @(negedge sclk);
    check_val("framing_no_echo", frames_seen, base);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    wait_frames("after_framing_count", base + 1);

    // Reset in the middle of the fourth data bit of an echo.
    repeat (600) @(negedge sclk);
    base = frames_seen;
    b = 8'($urandom);
    exp_q.push_back(b);
    fork
      send_byte(b, 1'b1);
    join_none
    n = 0;
    while (ser.rs232_tx === 1'b1 && n < 2000) begin
      @(negedge sclk);
      n++;
    end
    check_val("rst_mid_echo_started", 32'(ser.rs232_tx), 32'd0);
    repeat (4 * Bit + Bit / 2) @(negedge sclk);
    s_rst_n = 1'b1;
    exp_q.delete();
    @(negedge sclk);
    check_val("rst_mid_tx_high", 32'(ser.rs232_tx), 32'd1);
    repeat (40) @(negedge sclk);
    s_rst_n = 1'b0;
    repeat (1500) @(negedge sclk);
    check_val("rst_mid_no_echo", frames_seen, base);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    wait_frames("after_rst_count", base + 1);

    // Frame sent while reset is held is never echoed.
    repeat (600) @(negedge sclk);
    base = frames_seen;
    s_rst_n = 1'b1;
    repeat (5) @(negedge sclk);
    low0 = tx_low_cnt;
    send_byte(8'($urandom), 1'b1);
    check_val("rst_held_tx_high", tx_low_cnt, low0);
    repeat (20) @(negedge sclk);
    s_rst_n = 1'b0;
    repeat (1500) @(negedge sclk);
    check_val("rst_held_no_echo", frames_seen, base);

    // Random traffic with occasional framing errors and random gaps.
    base = frames_seen;
    n_good = 0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      if (good) begin
        exp_q.push_back(b);
        n_good++;
      end
      send_byte(b, good);
      repeat (good ? $urandom_range(0, 80) : $urandom_range(20, 80)) @(negedge sclk);
    end
    wait_frames("random_count", base + n_good);
    repeat (800) @(negedge sclk);
    check_val("random_drained", 32'(exp_q.size()), 32'd0);
    check_val("random_no_extra", frames_seen, base + n_good);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
